// File: rtl/pong_clk_pkg.sv
// Shared definitions for the Pong clock/reset domain: sequencer states and
// default divider/stabilisation constants.
package pong_clk_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK,
        STABILIZE,
        HOLD,
        RUN
    } seq_state_t;

    localparam int PLL_FAST_DIV   = 8;
    localparam int SEQ_STABLE_DEF = 1024;

    function automatic int maxOf(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level signal.
// All stages clear to 0 on the synchronous active-low reset.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/pll_reset_seq.sv
// Reset/clock-enable sequencer behind the core PLL: waits for a stable lock,
// holds the core in reset while pixel enables run, then supervises lock loss.
module pll_reset_seq
    import pong_clk_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = SEQ_STABLE_DEF,
    parameter int RESET_HOLD    = 64,
    parameter int CE_DIV        = PLL_FAST_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       user_reset,
    output logic       core_rst_n,
    output logic       ce_pix,
    output logic       ce_half,
    output logic       lock_lost,
    output logic [7:0] relock_cnt
);

    localparam int CNT_W = $clog2(maxOf(STABLE_CYCLES, RESET_HOLD) + 1);
    localparam int DIV_W = $clog2(CE_DIV);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD - 1);
    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(CE_DIV - 1);

    seq_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div;
    logic             r_half_ph;
    logic             r_core_rst_n;
    logic             r_ce_pix;
    logic             r_ce_half;
    logic             r_lock_lost;
    logic [7:0]       r_relock_cnt;

    logic             w_locked_s;
    logic [DIV_W-1:0] w_div_nxt;
    logic             w_pix_nxt;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_sync_locked (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_d     (pll_locked),
        .o_q     (w_locked_s)
    );

    // Enables are registered from the divider's next value so ce_pix lands
    // exactly on the last phase of each CE_DIV window.
    assign w_div_nxt = (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
    assign w_pix_nxt = (w_div_nxt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= WAIT_LOCK;
            r_cnt        <= '0;
            r_div        <= '0;
            r_half_ph    <= 1'b0;
            r_core_rst_n <= 1'b0;
            r_ce_pix     <= 1'b0;
            r_ce_half    <= 1'b0;
            r_lock_lost  <= 1'b0;
            r_relock_cnt <= '0;
        end else begin
            r_ce_pix  <= 1'b0;
            r_ce_half <= 1'b0;
            case (r_state)
                WAIT_LOCK: begin
                    r_core_rst_n <= 1'b0;
                    r_div        <= '0;
                    r_half_ph    <= 1'b0;
                    if (w_locked_s) begin
                        r_state <= STABILIZE;
                        r_cnt   <= '0;
                    end
                end
                STABILIZE: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (!w_locked_s) begin
                        r_state <= WAIT_LOCK;
                    end else if (r_cnt == STABLE_LAST) begin
                        r_state   <= HOLD;
                        r_cnt     <= '0;
                        r_div     <= '0;
                        r_half_ph <= 1'b0;
                    end
                end
                HOLD, RUN: begin
                    // Lock loss wins over user_reset; only a loss in RUN is counted.
                    if (!w_locked_s) begin
                        r_state      <= WAIT_LOCK;
                        r_core_rst_n <= 1'b0;
                        r_div        <= '0;
                        r_half_ph    <= 1'b0;
                        if (r_state == RUN) begin
                            r_lock_lost <= 1'b1;
                            if (r_relock_cnt != 8'hFF) begin
                                r_relock_cnt <= r_relock_cnt + 8'd1;
                            end
                        end
                    end else begin
                        r_div     <= w_div_nxt;
                        r_ce_pix  <= w_pix_nxt;
                        r_ce_half <= w_pix_nxt & r_half_ph;
                        if (w_pix_nxt) begin
                            r_half_ph <= ~r_half_ph;
                        end
                        if (user_reset) begin
                            r_state      <= HOLD;
                            r_cnt        <= '0;
                            r_core_rst_n <= 1'b0;
                        end else if (r_state == HOLD) begin
                            r_cnt <= r_cnt + CNT_W'(1);
                            if (r_cnt == HOLD_LAST) begin
                                r_state      <= RUN;
                                r_core_rst_n <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    r_state      <= WAIT_LOCK;
                    r_core_rst_n <= 1'b0;
                end
            endcase
        end
    end

    assign core_rst_n = r_core_rst_n;
    assign ce_pix     = r_ce_pix;
    assign ce_half    = r_ce_half;
    assign lock_lost  = r_lock_lost;
    assign relock_cnt = r_relock_cnt;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed bench for pll_reset_seq: table-driven power-up checkpoints plus
// hand-written sequences for glitches, lock loss, user reset and mid-run reset.
module tb_pll_reset_seq;

    localparam int SYNC   = 2;
    localparam int STABLE = 16;
    localparam int HOLDC  = 4;
    localparam int DIV    = 8;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       pll_locked = 1'b0;
    logic       user_reset = 1'b0;
    logic       core_rst_n;
    logic       ce_pix;
    logic       ce_half;
    logic       lock_lost;
    logic [7:0] relock_cnt;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int   cycle;
        logic expRst;
        logic expPix;
        logic expHalf;
    } vec_t;

    vec_t vecs[11];

    always #5 clk = ~clk;

    pll_reset_seq #(
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STABLE),
        .RESET_HOLD    (HOLDC),
        .CE_DIV        (DIV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .user_reset (user_reset),
        .core_rst_n (core_rst_n),
        .ce_pix     (ce_pix),
        .ce_half    (ce_half),
        .lock_lost  (lock_lost),
        .relock_cnt (relock_cnt)
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic applyStimulus(input logic rn, input logic lk, input logic ur);
        rst_n      = rn;
        pll_locked = lk;
        user_reset = ur;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
        end
    endtask

    task automatic waitCoreRun(input int bound);
        int n = 0;
        while (core_rst_n !== 1'b1 && n < bound) begin
            tick(1);
            n++;
        end
        checkOutput("runTimeout", {7'd0, core_rst_n}, 8'd1);
    endtask

    task automatic waitPix(input int bound);
        int n = 0;
        while (ce_pix !== 1'b1 && n < bound) begin
            tick(1);
            n++;
        end
        checkOutput("pixTimeout", {7'd0, ce_pix}, 8'd1);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int p;
        int s;
        int t;
        int f;
        int lowCnt;
        int pixCnt;

        vecs[0]  = '{12, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{32, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{33, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{35, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{36, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{37, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{43, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{44, 1'b1, 1'b1, 1'b1};
        vecs[8]  = '{52, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{60, 1'b1, 1'b1, 1'b1};
        vecs[10] = '{61, 1'b1, 1'b0, 1'b0};

        // Reset state
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick(3);
        checkOutput("rstCoreRstN", {7'd0, core_rst_n}, 8'd0);
        checkOutput("rstCePix", {7'd0, ce_pix}, 8'd0);
        checkOutput("rstCeHalf", {7'd0, ce_half}, 8'd0);
        checkOutput("rstLockLost", {7'd0, lock_lost}, 8'd0);
        checkOutput("rstRelockCnt", relock_cnt, 8'd0);

        // Clean power-up, lock raised at cycle 10
        applyStimulus(1'b1, 1'b0, 1'b0);
        base = cyc;
        tick(10);
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 11; i++) begin
            while (cyc < base + vecs[i].cycle) tick(1);
            checkOutput($sformatf("pwrRst@%0d", vecs[i].cycle), {7'd0, core_rst_n}, {7'd0, vecs[i].expRst});
            checkOutput($sformatf("pwrPix@%0d", vecs[i].cycle), {7'd0, ce_pix}, {7'd0, vecs[i].expPix});
            checkOutput($sformatf("pwrHalf@%0d", vecs[i].cycle), {7'd0, ce_half}, {7'd0, vecs[i].expHalf});
        end
        checkOutput("pwrLockLost", {7'd0, lock_lost}, 8'd0);

        // User reset in RUN: core reset low for exactly 4 cycles, enables unbroken
        waitPix(10);
        p = cyc;
        tick(2);
        checkOutput("urBefore", {7'd0, core_rst_n}, 8'd1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        tick(1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        lowCnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (core_rst_n === 1'b0) lowCnt++;
            if (cyc == p + 7) checkOutput("urRunAgain", {7'd0, core_rst_n}, 8'd1);
            if (cyc == p + 8) begin
                checkOutput("urPixP8", {7'd0, ce_pix}, 8'd1);
                checkOutput("urHalfP8", {7'd0, ce_half}, 8'd1);
            end
            tick(1);
        end
        checkOutput("urLowCycles", lowCnt[7:0], 8'd4);
        tick(3);
        checkOutput("urPixP16", {7'd0, ce_pix}, 8'd1);
        checkOutput("urHalfP16", {7'd0, ce_half}, 8'd0);
        tick(1);
        checkOutput("urPixP17", {7'd0, ce_pix}, 8'd0);

        // Simultaneous lock loss and user reset in RUN
        tick(2);
        s = cyc;
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick(2);
        applyStimulus(1'b1, 1'b0, 1'b1);
        tick(1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("simLockLost", {7'd0, lock_lost}, 8'd1);
        checkOutput("simRelock", relock_cnt, 8'd1);
        pixCnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (ce_pix === 1'b1) pixCnt++;
            if (cyc == s + 4) checkOutput("simCoreRst", {7'd0, core_rst_n}, 8'd0);
            tick(1);
        end
        checkOutput("simNoPix", pixCnt[7:0], 8'd0);

        // Back to RUN, then block reset mid-run clears everything
        applyStimulus(1'b1, 1'b1, 1'b0);
        waitCoreRun(40);
        tick(3);
        applyStimulus(1'b0, 1'b1, 1'b0);
        tick(1);
        checkOutput("midRstCore", {7'd0, core_rst_n}, 8'd0);
        checkOutput("midRstPix", {7'd0, ce_pix}, 8'd0);
        checkOutput("midRstHalf", {7'd0, ce_half}, 8'd0);
        checkOutput("midRstLost", {7'd0, lock_lost}, 8'd0);
        checkOutput("midRstRelock", relock_cnt, 8'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick(1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick(2);

        // Glitchy lock: high 5, low 1, high; final STABILIZE entry at t+9
        t = cyc;
        applyStimulus(1'b1, 1'b1, 1'b0);
        tick(5);
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick(1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        tick(t + 23 - cyc);
        checkOutput("glitchNoEarly", {7'd0, core_rst_n}, 8'd0);
        tick(5);
        checkOutput("glitchStillHeld", {7'd0, core_rst_n}, 8'd0);
        tick(1);
        checkOutput("glitchRise", {7'd0, core_rst_n}, 8'd1);
        checkOutput("glitchLockLost", {7'd0, lock_lost}, 8'd0);

        // Lock loss in RUN, then saturation of relock_cnt
        tick(3);
        f = cyc;
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick(1);
        checkOutput("lossEarlyRst", {7'd0, core_rst_n}, 8'd1);
        checkOutput("lossEarlyLost", {7'd0, lock_lost}, 8'd0);
        tick(f + 4 - cyc);
        checkOutput("lossRst", {7'd0, core_rst_n}, 8'd0);
        checkOutput("lossLost", {7'd0, lock_lost}, 8'd1);
        checkOutput("lossRelock", relock_cnt, 8'd1);
        for (int i = 2; i <= 300; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0);
            waitCoreRun(40);
            applyStimulus(1'b1, 1'b0, 1'b0);
            tick(5);
            if (i == 100) checkOutput("relock100", relock_cnt, 8'd100);
            if (i == 255) checkOutput("relock255", relock_cnt, 8'd255);
        end
        checkOutput("relockSat", relock_cnt, 8'd255);
        checkOutput("relockLost", {7'd0, lock_lost}, 8'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
